// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// The special-case constants are given at the native 32-bit width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    localparam logic [MDU_WIDTH-1:0] MDU_DIV0_QUOT = '1;
    localparam logic [MDU_WIDTH-1:0] MDU_OVF_QUOT  = 32'h8000_0000;
    localparam logic [MDU_WIDTH-1:0] MDU_OVF_REM   = '0;

    function automatic logic op_is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic op_signed_a(input mdu_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input mdu_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and emit the resulting quotient bit.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign shifted = {rem_in, next_bit};
    // The true difference is below the divisor whenever it is kept, so the
    // low WIDTH bits of the modular subtraction are exact.
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, with the sign fix-up on the last step.
//
// state | meaning
// IDLE  | waiting for start; result holds last value
// CALC  | iterating, counter counts 0..WIDTH-1
// DONE  | result_valid high until result_ack
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             result_ack,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [WIDTH-1:0] MIN_INT   = {MDU_OVF_QUOT[MDU_WIDTH-1], {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] DIV0_QUOT = {WIDTH{MDU_DIV0_QUOT[0]}};
    localparam logic [WIDTH-1:0] OVF_REM   = {WIDTH{MDU_OVF_REM[0]}};
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;

    logic [1:0]         state;
    mdu_op_t            op;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   result_q;

    mdu_op_t          new_op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             is_div0;
    logic             is_ovf;
    logic [WIDTH-1:0] special_res;
    logic             accept;

    assign new_op  = mdu_op_t'(funct3);
    assign sign_a  = op_signed_a(new_op) & src_a[WIDTH-1];
    assign sign_b  = op_signed_b(new_op) & src_b[WIDTH-1];
    assign mag_a   = sign_a ? -src_a : src_a;
    assign mag_b   = sign_b ? -src_b : src_b;
    assign is_div0 = op_is_div(new_op) && (src_b == '0);
    assign is_ovf  = ((new_op == OP_DIV) || (new_op == OP_REM)) &&
                     (src_a == MIN_INT) && (src_b == ALL_ONES);
    assign special_res = is_div0 ? (new_op[1] ? src_a : DIV0_QUOT)
                                 : (new_op[1] ? OVF_REM : MIN_INT);
    assign accept  = start && ((state == S_IDLE) || ((state == S_DONE) && result_ack));

    // Multiply: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits then quotient bits}.
    logic [WIDTH-1:0]   div_rem;
    logic               div_q;
    logic [2*WIDTH-1:0] div_next;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in   (acc[2*WIDTH-1:WIDTH]),
        .next_bit (acc[WIDTH-1]),
        .divisor  (opnd),
        .rem_out  (div_rem),
        .q_bit    (div_q)
    );

    assign div_next = {div_rem, acc[WIDTH-2:0], div_q};

    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   final_res;
    logic               last_iter;

    assign acc_next  = op_is_div(op) ? div_next : mul_next;
    assign quot      = acc_next[WIDTH-1:0];
    assign rem       = acc_next[2*WIDTH-1:WIDTH];
    assign last_iter = (count == CW'(WIDTH-1));

    always_comb begin
        prod_fix  = neg_res ? -acc_next : acc_next;
        final_res = '0;
        if (op_is_div(op)) begin
            if (op[1]) final_res = neg_rem ? -rem : rem;
            else       final_res = neg_res ? -quot : quot;
        end else if (op == OP_MUL) begin
            final_res = prod_fix[WIDTH-1:0];
        end else begin
            final_res = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            op       <= OP_MUL;
            opnd     <= '0;
            acc      <= '0;
            count    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (accept) begin
            op      <= new_op;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            count   <= '0;
            if (is_div0 || is_ovf) begin
                state    <= S_DONE;
                result_q <= special_res;
            end else begin
                state <= S_CALC;
                opnd  <= op_is_div(new_op) ? mag_b : mag_a;
                acc   <= {{WIDTH{1'b0}}, (op_is_div(new_op) ? mag_a : mag_b)};
            end
        end else begin
            case (state)
                S_IDLE: ;
                S_CALC: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        state    <= S_DONE;
                        result_q <= final_res;
                    end
                end
                S_DONE: if (result_ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state == S_CALC) || (state == S_DONE);
    assign result_valid = (state == S_DONE);
    assign result       = result_q;

endmodule
